timer_ctrl_master: RTL and testbench

- Avalon-MM initiator that owns one 16-bit interval-timer slave: sys_clk timer register map, 3-bit word address, fixed 1-cycle registered read latency, no waitrequest.
- Turns simple fabric-side commands (start, stop, snapshot) into timer register write/read sequences.
- Services the timer IRQ in hardware by clearing status, counting ticks and pulsing `tick`.
- Sits beside the timer in the application_selector system so hardware logic gets a periodic tick without a CPU.

---
 rtl/timer_regs_pkg.sv | 53 +++++
 rtl/timer_ctrl_master.sv | 151 +++++++++++++++
 tb/tb_timer_ctrl_master.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_regs_pkg.sv
// timer_regs_pkg: interval-timer register map, control bits, bus command type and master FSM states.
package timer_regs_pkg;

    localparam logic [2:0] TMR_STATUS   = 3'd0;
    localparam logic [2:0] TMR_CONTROL  = 3'd1;
    localparam logic [2:0] TMR_PERIOD_L = 3'd2;
    localparam logic [2:0] TMR_PERIOD_H = 3'd3;
    localparam logic [2:0] TMR_SNAP_L   = 3'd4;
    localparam logic [2:0] TMR_SNAP_H   = 3'd5;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    typedef enum logic [3:0] {
        IDLE, WR_PL, WR_PH, WR_CTRL, WR_STOP, ACK, SNAP_WR, SNAP_RL, SNAP_RH, SNAP_DONE
    } tmr_state_e;

    typedef struct packed {
        logic        cs;
        logic        write_n;
        logic [2:0]  addr;
        logic [15:0] wdata;
    } av_cmd_t;

    localparam av_cmd_t AV_IDLE = '{cs: 1'b0, write_n: 1'b1, addr: 3'd0, wdata: 16'd0};

    function automatic av_cmd_t av_wr(input logic [2:0] a, input logic [15:0] d);
        return '{cs: 1'b1, write_n: 1'b0, addr: a, wdata: d};
    endfunction

    function automatic av_cmd_t av_rd(input logic [2:0] a);
        return '{cs: 1'b1, write_n: 1'b1, addr: a, wdata: 16'd0};
    endfunction

    function automatic logic [15:0] ctrl_start_word(input logic cont);
        logic [15:0] w;
        w = '0;
        w[CTRL_ITO]   = 1'b1;
        w[CTRL_CONT]  = cont;
        w[CTRL_START] = 1'b1;
        return w;
    endfunction

    function automatic logic [15:0] ctrl_stop_word();
        logic [15:0] w;
        w = '0;
        w[CTRL_STOP] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/timer_ctrl_master.sv
// timer_ctrl_master: Avalon-MM initiator that starts, stops, snapshots and services a 16-bit interval timer.
module timer_ctrl_master
    import timer_regs_pkg::*;
#(
    parameter logic CONTINUOUS = 1'b1,
    parameter int   TICK_WIDTH = 32,
    parameter int   RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [31:0]           cfg_period,
    input  logic                  start_req,
    input  logic                  stop_req,
    input  logic                  snap_req,
    output logic                  busy,
    output logic                  snap_valid,
    output logic [31:0]           snap_value,
    output logic [31:0]           elapsed,
    output logic                  tick,
    output logic [TICK_WIDTH-1:0] tick_count,
    output logic [2:0]            av_address,
    output logic                  av_chipselect,
    output logic                  av_write_n,
    output logic [15:0]           av_writedata,
    input  logic [15:0]           av_readdata,
    input  logic                  timer_irq
);

    if (RD_LATENCY != 1) begin : g_rd_latency_check
        $error("timer_ctrl_master supports RD_LATENCY=1 only");
    end

    tmr_state_e            state_q, state_d;
    logic                  start_pend_q, start_pend_d;
    logic                  stop_pend_q, stop_pend_d;
    logic                  snap_pend_q, snap_pend_d;
    logic [31:0]           period_q, period_d;
    logic [TICK_WIDTH-1:0] tick_count_q, tick_count_d;
    logic                  tick_q, tick_d;
    logic [31:0]           snap_value_q, snap_value_d;
    logic [31:0]           elapsed_q, elapsed_d;
    logic                  snap_valid_q, snap_valid_d;
    av_cmd_t               bus_q, bus_d;
    logic                  take_stop, take_start, take_snap;

    always_comb begin
        state_d      = state_q;
        take_stop    = 1'b0;
        take_start   = 1'b0;
        take_snap    = 1'b0;
        period_d     = period_q;
        tick_count_d = tick_count_q;
        snap_value_d = snap_value_q;
        elapsed_d    = elapsed_q;
        case (state_q)
            IDLE: begin
                if (timer_irq) begin
                    state_d = ACK;
                end else if (stop_pend_q) begin
                    state_d   = WR_STOP;
                    take_stop = 1'b1;
                end else if (start_pend_q) begin
                    state_d      = WR_PL;
                    take_start   = 1'b1;
                    period_d     = cfg_period;
                    tick_count_d = '0;
                end else if (snap_pend_q) begin
                    state_d   = SNAP_WR;
                    take_snap = 1'b1;
                end
            end
            WR_PL:   state_d = WR_PH;
            WR_PH:   state_d = WR_CTRL;
            SNAP_WR: state_d = SNAP_RL;
            SNAP_RL: state_d = SNAP_RH;
            SNAP_RH: begin
                state_d            = SNAP_DONE;
                snap_value_d[15:0] = av_readdata;
            end
            SNAP_DONE: begin
                state_d             = IDLE;
                snap_value_d[31:16] = av_readdata;
                elapsed_d           = period_q - {av_readdata, snap_value_q[15:0]};
            end
            default: state_d = IDLE;
        endcase
        tick_d       = (state_d == ACK);
        tick_count_d = tick_count_d + TICK_WIDTH'(tick_d);
        snap_valid_d = (state_q == SNAP_DONE);
        // A stop request in the same cycle always cancels any start, pending or new.
        stop_pend_d  = (stop_pend_q & ~take_stop) | stop_req;
        start_pend_d = ((start_pend_q & ~take_start) | start_req) & ~stop_req;
        snap_pend_d  = (snap_pend_q & ~take_snap) | snap_req;
    end

    // Bus registers are loaded from the next state so each command appears during its own state.
    always_comb begin
        bus_d = AV_IDLE;
        case (state_d)
            WR_PL:   bus_d = av_wr(TMR_PERIOD_L, period_d[15:0]);
            WR_PH:   bus_d = av_wr(TMR_PERIOD_H, period_d[31:16]);
            WR_CTRL: bus_d = av_wr(TMR_CONTROL, ctrl_start_word(CONTINUOUS));
            WR_STOP: bus_d = av_wr(TMR_CONTROL, ctrl_stop_word());
            ACK:     bus_d = av_wr(TMR_STATUS, 16'd0);
            SNAP_WR: bus_d = av_wr(TMR_SNAP_L, 16'd0);
            SNAP_RL: bus_d = av_rd(TMR_SNAP_L);
            SNAP_RH: bus_d = av_rd(TMR_SNAP_H);
            default: bus_d = AV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            start_pend_q <= 1'b0;
            stop_pend_q  <= 1'b0;
            snap_pend_q  <= 1'b0;
            period_q     <= '0;
            tick_count_q <= '0;
            tick_q       <= 1'b0;
            snap_value_q <= '0;
            elapsed_q    <= '0;
            snap_valid_q <= 1'b0;
            bus_q        <= AV_IDLE;
        end else begin
            state_q      <= state_d;
            start_pend_q <= start_pend_d;
            stop_pend_q  <= stop_pend_d;
            snap_pend_q  <= snap_pend_d;
            period_q     <= period_d;
            tick_count_q <= tick_count_d;
            tick_q       <= tick_d;
            snap_value_q <= snap_value_d;
            elapsed_q    <= elapsed_d;
            snap_valid_q <= snap_valid_d;
            bus_q        <= bus_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign snap_valid    = snap_valid_q;
    assign snap_value    = snap_value_q;
    assign elapsed       = elapsed_q;
    assign tick          = tick_q;
    assign tick_count    = tick_count_q;
    assign av_chipselect = bus_q.cs;
    assign av_write_n    = bus_q.write_n;
    assign av_address    = bus_q.addr;
    assign av_writedata  = bus_q.wdata;

endmodule

// File: tb/tb_timer_ctrl_master.sv
// tb_timer_ctrl_master: directed and random stimulus against a behavioural interval-timer slave.
module tb_timer_ctrl_master;
    import timer_regs_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] cfg_period = '0;
    logic        start_req = 1'b0, stop_req = 1'b0, snap_req = 1'b0;
    logic        busy, snap_valid, tick;
    logic [31:0] snap_value, elapsed, tick_count;
    logic [2:0]  av_address;
    logic        av_chipselect, av_write_n;
    logic [15:0] av_writedata, av_readdata;
    logic        timer_irq;

    int total = 0;
    int bad = 0;

    timer_ctrl_master #(.CONTINUOUS(1'b1), .TICK_WIDTH(32), .RD_LATENCY(1)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_period(cfg_period),
        .start_req(start_req), .stop_req(stop_req), .snap_req(snap_req),
        .busy(busy), .snap_valid(snap_valid), .snap_value(snap_value), .elapsed(elapsed),
        .tick(tick), .tick_count(tick_count),
        .av_address(av_address), .av_chipselect(av_chipselect), .av_write_n(av_write_n),
        .av_writedata(av_writedata), .av_readdata(av_readdata), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural interval timer: period write loads and stops, counts down, flags timeout at zero.
    logic [15:0] s_per_l = '0, s_per_h = '0, s_ctrl = '0, s_rdata = '0;
    logic [31:0] s_cnt = '0, s_snap = '0;
    logic        s_run = 1'b0, s_to = 1'b0, inj = 1'b0;
    logic        s_wr;
    assign s_wr        = av_chipselect && !av_write_n;
    assign av_readdata = s_rdata;
    assign timer_irq   = s_to;

    always @(posedge clk) begin
        if (s_wr && av_address == TMR_STATUS) s_to <= 1'b0;
        if (s_run) begin
            if (s_cnt == 0) begin
                s_to  <= 1'b1;
                s_cnt <= {s_per_h, s_per_l};
                if (!s_ctrl[CTRL_CONT]) s_run <= 1'b0;
            end else begin
                s_cnt <= s_cnt - 1;
            end
        end
        if (s_wr) begin
            case (av_address)
                TMR_CONTROL: begin
                    s_ctrl <= av_writedata;
                    if (av_writedata[CTRL_START]) s_run <= 1'b1;
                    if (av_writedata[CTRL_STOP]) s_run <= 1'b0;
                end
                TMR_PERIOD_L: begin s_per_l <= av_writedata; s_run <= 1'b0; s_cnt <= {s_per_h, av_writedata}; end
                TMR_PERIOD_H: begin s_per_h <= av_writedata; s_run <= 1'b0; s_cnt <= {av_writedata, s_per_l}; end
                TMR_SNAP_L, TMR_SNAP_H: s_snap <= s_cnt;
                default: ;
            endcase
        end
        if (inj) s_to <= 1'b1;
        s_rdata <= (av_chipselect && av_write_n) ?
                   (av_address == TMR_SNAP_L ? s_snap[15:0] :
                    av_address == TMR_SNAP_H ? s_snap[31:16] :
                    av_address == TMR_CONTROL ? s_ctrl : {15'd0, s_to}) : 16'd0;
    end

    typedef struct { int c; logic [2:0] a; logic [15:0] d; logic w; } txn_t;
    txn_t        log_q[$];
    int          tick_q[$];
    int          valid_q[$];
    int          cyc = 0;
    int          busy_cnt = 0;
    int          mdl_ticks = 0;
    logic [31:0] exp_per = '0;
    logic [31:0] cfg_prev = '0;
    logic        ack_wr;

    // Bus-level model: ticks are serviced timeouts, period writes carry the period sampled at acceptance.
    always @(negedge clk) begin
        cyc++;
        busy_cnt += int'(busy);
        if (av_chipselect) log_q.push_back('{c: cyc, a: av_address, d: av_writedata, w: !av_write_n});
        if (tick) tick_q.push_back(cyc);
        if (snap_valid) valid_q.push_back(cyc);
        if (!reset_n) begin
            mdl_ticks = 0;
            exp_per   = '0;
        end
        ack_wr = av_chipselect && !av_write_n && av_address == TMR_STATUS;
        if (tick || ack_wr) chk("tick_with_ack", 32'(tick), 32'(ack_wr));
        if (ack_wr) begin
            mdl_ticks++;
            chk("ack_irq_set", 32'(s_to), 32'd1);
            chk("ack_data", 32'(av_writedata), 32'd0);
            chk("tick_count", tick_count, 32'(mdl_ticks));
        end
        if (av_chipselect && !av_write_n) begin
            if (av_address == TMR_PERIOD_L) begin
                exp_per = cfg_prev;
                chk("period_l", 32'(av_writedata), 32'(cfg_prev[15:0]));
            end
            if (av_address == TMR_PERIOD_H) chk("period_h", 32'(av_writedata), 32'(exp_per[31:16]));
            if (av_address == TMR_CONTROL) begin
                chk("ctrl_data", 32'(av_writedata == 16'h0007 || av_writedata == 16'h0008), 32'd1);
                if (av_writedata[CTRL_START]) mdl_ticks = 0;
            end
        end
        if (snap_valid) begin
            chk("snap_value", snap_value, s_snap);
            chk("elapsed", elapsed, exp_per - s_snap);
        end
        cfg_prev = cfg_period;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic req(input logic st, input logic sp, input logic sn);
        start_req = st;
        stop_req  = sp;
        snap_req  = sn;
        @(posedge clk);
        #1;
        start_req = 1'b0;
        stop_req  = 1'b0;
        snap_req  = 1'b0;
    endtask

    task automatic wait_wr(input string tag, input logic [2:0] a);
        int n = 0;
        while (!(av_chipselect && !av_write_n && av_address == a) && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(av_chipselect && !av_write_n && av_address == a), 32'd1);
    endtask

    function automatic int find_txn(input logic [2:0] a, input logic w);
        foreach (log_q[i]) if (log_q[i].a == a && log_q[i].w == w) return log_q[i].c;
        return -1;
    endfunction

    initial begin
        int n, b0, tq0, vq0, cw, sw, nonstat, vstart;
        logic [2:0]  a0;
        logic [15:0] d0;
        int r;

        cycles(3);
        chk("rst_cs", 32'(av_chipselect), 32'd0);
        chk("rst_write_n", 32'(av_write_n), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tick_count", tick_count, 32'd0);
        chk("rst_snap_valid", 32'(snap_valid), 32'd0);
        reset_n = 1'b1;
        cycles(2);

        cfg_period = 32'h000927BF;
        log_q.delete();
        b0 = busy_cnt;
        req(1'b1, 1'b0, 1'b0);
        cycles(8);
        chk("start_nwr", 32'(log_q.size()), 32'd3);
        if (log_q.size() == 3) begin
            chk("start_a0", 32'(log_q[0].a), 32'd2);
            chk("start_d0", 32'(log_q[0].d), 32'h27BF);
            chk("start_a1", 32'(log_q[1].a), 32'd3);
            chk("start_d1", 32'(log_q[1].d), 32'h0009);
            chk("start_a2", 32'(log_q[2].a), 32'd1);
            chk("start_d2", 32'(log_q[2].d), 32'h0007);
            chk("start_span", 32'(log_q[2].c - log_q[0].c), 32'd2);
        end
        chk("start_busy", 32'(busy_cnt - b0), 32'd3);

        cfg_period = 32'd9;
        tq0 = tick_q.size();
        req(1'b1, 1'b0, 1'b0);
        n = 0;
        while (tick_count < 3 && n < 200) begin cycles(1); n++; end
        chk("ticks3", tick_count, 32'd3);
        if (tick_q.size() >= tq0 + 3) begin
            chk("tick_gap1", 32'(tick_q[tq0+1] - tick_q[tq0]), 32'd10);
            chk("tick_gap2", 32'(tick_q[tq0+2] - tick_q[tq0+1]), 32'd10);
        end

        cycles(2);
        log_q.delete();
        vq0 = valid_q.size();
        req(1'b0, 1'b0, 1'b1);
        n = 0;
        while (valid_q.size() == vq0 && n < 30) begin cycles(1); n++; end
        chk("snap_seen", 32'(valid_q.size() > vq0), 32'd1);
        chk("snap_val4", snap_value, 32'd4);
        chk("snap_elapsed5", elapsed, 32'd5);
        cw = find_txn(TMR_SNAP_L, 1'b1);
        if (valid_q.size() > vq0) chk("snap_latency", 32'(valid_q[vq0] - cw), 32'd4);
        chk("snap_rd_l", 32'(find_txn(TMR_SNAP_L, 1'b0) - cw), 32'd1);
        chk("snap_rd_h", 32'(find_txn(TMR_SNAP_H, 1'b0) - cw), 32'd2);

        log_q.delete();
        req(1'b1, 1'b1, 1'b0);
        cycles(10);
        nonstat = 0;
        a0 = '0;
        d0 = '0;
        foreach (log_q[i]) if (log_q[i].a != TMR_STATUS) begin
            if (nonstat == 0) begin a0 = log_q[i].a; d0 = log_q[i].d; end
            nonstat++;
        end
        chk("ss_nwr", 32'(nonstat), 32'd1);
        chk("ss_addr", 32'(a0), 32'd1);
        chk("ss_data", 32'(d0), 32'h0008);

        cfg_period = 32'd100;
        log_q.delete();
        req(1'b1, 1'b0, 1'b0);
        wait_wr("irq_wr_pl_seen", TMR_PERIOD_L);
        inj = 1'b1;
        @(posedge clk);
        #1 inj = 1'b0;
        cycles(8);
        cw = find_txn(TMR_CONTROL, 1'b1);
        sw = find_txn(TMR_STATUS, 1'b1);
        chk("irq_ack_gap", 32'(sw - cw), 32'd2);
        chk("irq_tick_cyc", 32'(tick_q[$]), 32'(sw));
        chk("irq_tick_count", tick_count, 32'd1);
        req(1'b0, 1'b1, 1'b0);
        cycles(5);

        cfg_period = 32'd50;
        log_q.delete();
        req(1'b1, 1'b0, 1'b0);
        wait_wr("rst_wr_ph_seen", TMR_PERIOD_H);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_cs", 32'(av_chipselect), 32'd0);
        chk("arst_write_n", 32'(av_write_n), 32'd1);
        chk("arst_addr", 32'(av_address), 32'd0);
        chk("arst_wdata", 32'(av_writedata), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_snap", snap_value, 32'd0);
        cycles(2);
        reset_n = 1'b1;
        log_q.delete();
        cycles(10);
        chk("arst_no_ctrl", 32'(find_txn(TMR_CONTROL, 1'b1)), 32'hFFFF_FFFF);

        vstart = valid_q.size();
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 4) cfg_period = 32'($urandom_range(2, 40));
            start_req = (r < 4);
            stop_req  = (r >= 3 && r < 6);
            snap_req  = (r >= 6 && r < 18);
            inj       = ($urandom_range(0, 99) == 0);
            @(posedge clk);
            #1;
        end
        start_req = 1'b0;
        stop_req  = 1'b0;
        snap_req  = 1'b0;
        inj       = 1'b0;
        cycles(10);
        req(1'b0, 1'b1, 1'b0);
        cycles(10);
        chk("rand_snaps", 32'(valid_q.size() > vstart), 32'd1);
        chk("rand_idle", 32'(busy), 32'd0);
        chk("rand_tick_count", tick_count, 32'(mdl_ticks));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
